check_layer: RTL



---
 rtl/ms_pkg.sv | 35 +++
 rtl/check_layer_if.sv | 26 ++
 rtl/chk_min_acc.sv | 45 ++++
 rtl/check_layer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ms_pkg.sv
// Shared min-sum types and helpers for the check and variable layers of the
// neural offset min-sum decoder.
package ms_pkg;

    localparam int MSG_W   = 8;
    localparam int MAG_MAX = 127;

    typedef logic signed [MSG_W-1:0] msg_t;
    typedef logic        [MSG_W-2:0] mag_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } chk_state_t;

    // |x| with the one unrepresentable magnitude (-128) pinned to 127
    function automatic mag_t sat_abs(input msg_t x);
        if (x == msg_t'(-128))
            return mag_t'(MAG_MAX);
        else if (x[MSG_W-1])
            return mag_t'(-x);
        else
            return mag_t'(x);
    endfunction

    function automatic mag_t sat_sub_offset(input mag_t m, input logic [MSG_W-1:0] off);
        if ({1'b0, m} > off)
            return m - off[MSG_W-2:0];
        else
            return '0;
    endfunction

endpackage

// File: rtl/check_layer_if.sv
// Handshake and message bus between the check layer and its driver.
interface check_layer_if
    import ms_pkg::*;
#(
    parameter int N_V = 44,
    parameter int N_C = 12,
    parameter int E   = 147
);
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] tanner_g [0:E-1][0:1];
    msg_t       var_msg  [0:E-1];
    logic [7:0] offset;
    msg_t       chk_msg  [0:E-1];

    modport master (
        output start, tanner_g, var_msg, offset,
        input  busy, done, chk_msg
    );

    modport slave (
        input  start, tanner_g, var_msg, offset,
        output busy, done, chk_msg
    );
endinterface

// File: rtl/chk_min_acc.sv
// Per-check-node accumulator: two smallest magnitudes, index of the smallest,
// and running sign parity.
module chk_min_acc
    import ms_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  mag_t          mag,
    input  logic          sgn,
    input  logic [EW-1:0] e,
    output mag_t          min1,
    output mag_t          min2,
    output logic [EW-1:0] idx,
    output logic          parity
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min1   <= mag_t'(MAG_MAX);
            min2   <= mag_t'(MAG_MAX);
            idx    <= '0;
            parity <= 1'b0;
        end else if (clear) begin
            min1   <= mag_t'(MAG_MAX);
            min2   <= mag_t'(MAG_MAX);
            idx    <= '0;
            parity <= 1'b0;
        end else if (en) begin
            // strict compare keeps the earliest index on ties
            if (mag < min1) begin
                min2 <= min1;
                min1 <= mag;
                idx  <= e;
            end else if (mag < min2) begin
                min2 <= mag;
            end
            parity <= parity ^ sgn;
        end
    end

endmodule

// File: rtl/check_layer.sv
// Check-node half of the offset min-sum decoder: per check node, one pass
// gathers min1/min2/parity, a second pass writes each edge's outgoing message.
module check_layer
    import ms_pkg::*;
#(
    parameter int N_V = 44,
    parameter int N_C = 12,
    parameter int E   = 147
) (
    input  logic          clk,
    input  logic          rst,
    check_layer_if.slave  bus
);

    localparam int EW = (E > 1)   ? $clog2(E)   : 1;
    localparam int CW = (N_C > 1) ? $clog2(N_C) : 1;

    chk_state_t    state, state_d;
    logic [EW-1:0] e_q, e_d;
    logic [CW-1:0] c_q, c_d;
    msg_t          chk_q [0:E-1];

    logic          clear_all, acc_clr, acc_en, wr_en;
    logic          hit, last_e, last_c, s;
    msg_t          cur, wr_val;
    mag_t          min1, min2, m_sel, m_off;
    logic [EW-1:0] idx;
    logic          parity;

    chk_min_acc #(.EW(EW)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clr),
        .en     (acc_en),
        .mag    (sat_abs(cur)),
        .sgn    (cur[MSG_W-1]),
        .e      (e_q),
        .min1   (min1),
        .min2   (min2),
        .idx    (idx),
        .parity (parity)
    );

    always_comb begin
        cur    = bus.var_msg[e_q];
        hit    = (bus.tanner_g[e_q][1] == 8'(c_q));
        last_e = (e_q == EW'(E - 1));
        last_c = (c_q == CW'(N_C - 1));
        // excluding the edge itself: the minimum holder sees min2, all others min1
        m_sel  = (e_q == idx) ? min2 : min1;
        m_off  = sat_sub_offset(m_sel, bus.offset);
        s      = parity ^ cur[MSG_W-1];
        wr_val = s ? -msg_t'({1'b0, m_off}) : msg_t'({1'b0, m_off});
    end

    always_comb begin
        state_d   = state;
        e_d       = e_q;
        c_d       = c_q;
        clear_all = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SCAN;
                    e_d       = '0;
                    c_d       = '0;
                    clear_all = 1'b1;
                    acc_clr   = 1'b1;
                end
            end
            SCAN: begin
                acc_en = hit;
                if (last_e) begin
                    state_d = EMIT;
                    e_d     = '0;
                end else begin
                    e_d = e_q + 1'b1;
                end
            end
            EMIT: begin
                wr_en = hit;
                if (last_e) begin
                    e_d = '0;
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        c_d     = c_q + 1'b1;
                        acc_clr = 1'b1;
                    end
                end else begin
                    e_d = e_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            e_q   <= '0;
            c_q   <= '0;
            for (int unsigned i = 0; i < E; i++)
                chk_q[i] <= '0;
        end else begin
            state <= state_d;
            e_q   <= e_d;
            c_q   <= c_d;
            if (clear_all) begin
                for (int unsigned i = 0; i < E; i++)
                    chk_q[i] <= '0;
            end else if (wr_en) begin
                chk_q[e_q] <= wr_val;
            end
        end
    end

    assign bus.busy    = (state == SCAN) || (state == EMIT);
    assign bus.done    = (state == DONE);
    assign bus.chk_msg = chk_q;

endmodule
